// File: rtl/mgt_01_fp_div_unit_pkg.sv
// rtl/mgt_01_fp_div_unit_pkg.sv - shared FP types, constants and divider FSM states
package mgt_01_fp_div_unit_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [23:0] significand;
  } effective_float_t;

  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } fu_state_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PREPARE   = 2'd1,
    DIVIDE    = 2'd2,
    NORMALIZE = 2'd3
  } fp_div_state_e;

  localparam int              QBITS_DEFAULT = 26;
  localparam logic signed [9:0] BIAS      = 10'sd127;
  localparam float_t          P_INFTY     = 32'h7F80_0000;
  localparam float_t          N_INFTY     = 32'hFF80_0000;
  localparam float_t          ZERO        = 32'h0000_0000;
  localparam float_t          QUIET_NAN   = 32'h7FC0_0000;

  // Hidden bit comes from a nonzero exponent, so denormals carry no integer bit.
  function automatic effective_float_t to_effective(input float_t f);
    effective_float_t e;
    e.sign        = f.sign;
    e.exponent    = f.exponent;
    e.significand = {|f.exponent, f.mantissa};
    return e;
  endfunction

endpackage

// File: rtl/mgt_01_radix2_divider.sv
// rtl/mgt_01_radix2_divider.sv - radix-2 restoring significand divider, one quotient bit per enabled cycle
module mgt_01_radix2_divider
  import mgt_01_fp_div_unit_pkg::*;
#(
  parameter int QBITS = QBITS_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             start_i,
  input  logic [23:0]      dividend_i,
  input  logic [23:0]      divisor_i,
  output logic [QBITS-1:0] quot_o,
  output logic             rem_nz_o,
  output logic             done_o
);

  localparam int CW = $clog2(QBITS);

  logic [24:0]      rem_q, rem_d;
  logic [24:0]      diff;
  logic [23:0]      div_q, div_d;
  logic [QBITS-1:0] quot_q, quot_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             ge;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rem_q  <= '0;
      div_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else if (en_i) begin
      rem_q  <= rem_d;
      div_q  <= div_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
    end
  end

  always_comb begin
    rem_d  = rem_q;
    div_d  = div_q;
    quot_d = quot_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    ge     = rem_q >= {1'b0, div_q};
    diff   = rem_q - {1'b0, div_q};
    if (start_i) begin
      rem_d  = {1'b0, dividend_i};
      div_d  = divisor_i;
      quot_d = '0;
      cnt_d  = CW'(QBITS - 1);
      run_d  = 1'b1;
    end else if (run_q) begin
      // Remainder stays below 2*divisor, so 25 bits never overflow after the shift.
      quot_d = {quot_q[QBITS-2:0], ge};
      rem_d  = ge ? (diff << 1) : (rem_q << 1);
      cnt_d  = cnt_q - CW'(1);
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end
    end
  end

  assign quot_o   = quot_q;
  assign rem_nz_o = |rem_q;
  assign done_o   = run_q && (cnt_q == '0);

endmodule

// File: rtl/mgt_01_fp_div_unit.sv
// rtl/mgt_01_fp_div_unit.sv - iterative single-precision FP divider; FP_DIV_ROUND_EN selects round-to-nearest-even
module mgt_01_fp_div_unit
  import mgt_01_fp_div_unit_pkg::*;
#(
  parameter int QBITS = QBITS_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clk_en_i,
  input  logic        valid_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] result_o,
  output logic        valid_o,
  output fu_state_e   fu_state_o,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic        invalid_op_o,
  output logic        div_by_zero_o
);

  fp_div_state_e     state_q, state_d;
  effective_float_t  opa_q, opa_d, opb_q, opb_d;
  logic              sign_q, sign_d;
  logic signed [9:0] exp_q, exp_d;
  logic              sp_q, sp_d;
  float_t            sp_res_q, sp_res_d;
  logic              sp_inv_q, sp_inv_d, sp_dbz_q, sp_dbz_d;
  float_t            result_q, result_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d, udf_q, udf_d, inv_q, inv_d, dbz_q, dbz_d;

  logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic              special;
  logic              div_start, div_done, rem_nz;
  logic [QBITS-1:0]  quot;
  logic [QBITS-1:0]  qn;
  logic signed [9:0] en;
  logic [22:0]       mant;

  mgt_01_radix2_divider #(.QBITS(QBITS)) u_div (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .en_i       (clk_en_i),
    .start_i    (div_start),
    .dividend_i (opa_q.significand),
    .divisor_i  (opb_q.significand),
    .quot_o     (quot),
    .rem_nz_o   (rem_nz),
    .done_o     (div_done)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      sp_q     <= 1'b0;
      sp_res_q <= ZERO;
      sp_inv_q <= 1'b0;
      sp_dbz_q <= 1'b0;
      result_q <= ZERO;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      inv_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else if (clk_en_i) begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      sp_q     <= sp_d;
      sp_res_q <= sp_res_d;
      sp_inv_q <= sp_inv_d;
      sp_dbz_q <= sp_dbz_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      inv_q    <= inv_d;
      dbz_q    <= dbz_d;
    end
  end

  always_comb begin
    a_zero  = opa_q.exponent == 8'h00;
    b_zero  = opb_q.exponent == 8'h00;
    a_inf   = (opa_q.exponent == 8'hFF) && (opa_q.significand[22:0] == '0);
    b_inf   = (opb_q.exponent == 8'hFF) && (opb_q.significand[22:0] == '0);
    a_nan   = (opa_q.exponent == 8'hFF) && (opa_q.significand[22:0] != '0);
    b_nan   = (opb_q.exponent == 8'hFF) && (opb_q.significand[22:0] != '0);
    special = a_zero || b_zero || a_inf || b_inf || a_nan || b_nan;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (valid_i) state_d = PREPARE;
      PREPARE:   state_d = special ? NORMALIZE : DIVIDE;
      DIVIDE:    if (div_done) state_d = NORMALIZE;
      NORMALIZE: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    opa_d     = opa_q;
    opb_d     = opb_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    sp_d      = sp_q;
    sp_res_d  = sp_res_q;
    sp_inv_d  = sp_inv_q;
    sp_dbz_d  = sp_dbz_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    inv_d     = inv_q;
    dbz_d     = dbz_q;
    div_start = 1'b0;
    qn        = quot;
    en        = exp_q;
    mant      = '0;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          opa_d = to_effective(float_t'(dividend_i));
          opb_d = to_effective(float_t'(divisor_i));
        end
      end
      PREPARE: begin
        sign_d    = opa_q.sign ^ opb_q.sign;
        exp_d     = $signed({2'b00, opa_q.exponent}) - $signed({2'b00, opb_q.exponent}) + BIAS;
        sp_d      = special;
        sp_inv_d  = 1'b0;
        sp_dbz_d  = 1'b0;
        div_start = !special;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          sp_res_d = QUIET_NAN;
          sp_inv_d = 1'b1;
        end else if (b_zero && !a_inf) begin
          sp_res_d = (opa_q.sign ^ opb_q.sign) ? N_INFTY : P_INFTY;
          sp_dbz_d = 1'b1;
        end else if (a_inf) begin
          sp_res_d = (opa_q.sign ^ opb_q.sign) ? N_INFTY : P_INFTY;
        end else begin
          sp_res_d = {opa_q.sign ^ opb_q.sign, 31'h0};
        end
      end
      NORMALIZE: begin
        valid_d = 1'b1;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        inv_d   = sp_inv_q;
        dbz_d   = sp_dbz_q;
        if (!qn[QBITS-1]) begin
          qn = qn << 1;
          en = en - 10'sd1;
        end
        mant = qn[QBITS-2 -: 23];
`ifdef FP_DIV_ROUND_EN
        // Guard is the first discarded bit; everything below it folds into sticky.
        if (qn[QBITS-25] && ((|qn[QBITS-26:0]) || rem_nz || mant[0])) begin
          if (&mant) en = en + 10'sd1;
          mant = mant + 23'd1;
        end
`endif
        if (sp_q) begin
          result_d = sp_res_q;
        end else if (en >= 10'sd255) begin
          result_d = sign_q ? N_INFTY : P_INFTY;
          ovf_d    = 1'b1;
        end else if (en <= 10'sd0) begin
          result_d = {sign_q, 31'h0};
          udf_d    = 1'b1;
        end else begin
          result_d = {sign_q, en[7:0], mant};
        end
      end
      default: ;
    endcase
  end

`ifndef FP_DIV_ROUND_EN
  logic unused_round;
  assign unused_round = ^{qn[QBITS-25:0], rem_nz};
`endif

  assign result_o      = result_q;
  assign valid_o       = valid_q;
  assign fu_state_o    = (state_q == IDLE) ? FREE : BUSY;
  assign overflow_o    = ovf_q;
  assign underflow_o   = udf_q;
  assign invalid_op_o  = inv_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_mgt_01_fp_div_unit.sv
// tb/tb_mgt_01_fp_div_unit.sv - directed self-checking bench for mgt_01_fp_div_unit
module tb_mgt_01_fp_div_unit;
  import mgt_01_fp_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] result;
  logic        valid_o;
  fu_state_e   fu_state;
  logic        ovf, udf, inv, dbz;
  int          total = 0;
  int          bad = 0;

`ifdef FP_DIV_ROUND_EN
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

  always #5 clk = ~clk;

  mgt_01_fp_div_unit dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .clk_en_i      (clk_en),
    .valid_i       (valid_i),
    .dividend_i    (a),
    .divisor_i     (b),
    .result_o      (result),
    .valid_o       (valid_o),
    .fu_state_o    (fu_state),
    .overflow_o    (ovf),
    .underflow_o   (udf),
    .invalid_op_o  (inv),
    .div_by_zero_o (dbz)
  );

  // Called 1 time unit after a rising edge; returns edges from accept until valid_o.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, output int lat);
    a = x;
    b = y;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({result, valid_o, ovf, udf, inv, dbz} !== 37'h0 || fu_state !== FREE) begin
      bad++;
      $display("FAIL reset_state: result=%h valid=%b flags=%b%b%b%b state=%0d, want all zero/FREE",
               result, valid_o, ovf, udf, inv, dbz, fu_state);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_normal;
    logic [31:0] va [4] = '{32'h40C00000, 32'hC0C00000, 32'h3F800000, 32'h3F800000};
    logic [31:0] vb [4] = '{32'h40000000, 32'h40000000, 32'h40400000, 32'h3F800000};
    logic [31:0] vr [4] = '{32'h40400000, 32'hC0400000, THIRD,        32'h3F800000};
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], lat);
      total++;
      if (lat !== 28 || result !== vr[i] || {ovf, udf, inv, dbz} !== 4'b0) begin
        bad++;
        $display("FAIL normal_%0d: lat=%0d result=%h flags=%b%b%b%b, want lat=28 result=%h flags=0000",
                 i, lat, result, ovf, udf, inv, dbz, vr[i]);
      end
    end
    @(posedge clk); #1;
    total++;
    if (valid_o !== 1'b0 || result !== 32'h3F800000) begin
      bad++;
      $display("FAIL valid_pulse: valid=%b result=%h, want valid=0 result held 3f800000", valid_o, result);
    end
  endtask

  task automatic test_special;
    logic [31:0] va [9] = '{32'h3F800000, 32'h00000000, 32'h7FC00001, 32'h7F800000, 32'h7F800000,
                            32'h80000000, 32'h40000000, 32'hBF800000, 32'h00400000};
    logic [31:0] vb [9] = '{32'h00000000, 32'h00000000, 32'h3F800000, 32'hFF800000, 32'hC0000000,
                            32'h40000000, 32'hFF800000, 32'h00000000, 32'h3F800000};
    logic [31:0] vr [9] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000,
                            32'h80000000, 32'h80000000, 32'hFF800000, 32'h00000000};
    logic [3:0]  vf [9] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                            4'b0000, 4'b0000, 4'b0001, 4'b0000};
    int lat;
    for (int i = 0; i < 9; i++) begin
      run_op(va[i], vb[i], lat);
      total++;
      if (lat !== 2 || result !== vr[i] || {ovf, udf, inv, dbz} !== vf[i]) begin
        bad++;
        $display("FAIL special_%0d: lat=%0d result=%h flags(ovf,udf,inv,dbz)=%b%b%b%b, want lat=2 result=%h flags=%b",
                 i, lat, result, ovf, udf, inv, dbz, vr[i], vf[i]);
      end
    end
  endtask

  task automatic test_range;
    int lat;
    run_op(32'h7F000000, 32'h00800000, lat);
    total++;
    if (lat !== 28 || result !== 32'h7F800000 || {ovf, udf, inv, dbz} !== 4'b1000) begin
      bad++;
      $display("FAIL overflow: lat=%0d result=%h flags=%b%b%b%b, want 28 7f800000 1000",
               lat, result, ovf, udf, inv, dbz);
    end
    run_op(32'h00800000, 32'h7F000000, lat);
    total++;
    if (lat !== 28 || result !== 32'h00000000 || {ovf, udf, inv, dbz} !== 4'b0100) begin
      bad++;
      $display("FAIL underflow: lat=%0d result=%h flags=%b%b%b%b, want 28 00000000 0100",
               lat, result, ovf, udf, inv, dbz);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    run_op(32'h40C00000, 32'h40000000, lat);
    total++;
    if (valid_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first: valid=%b lat=%0d, want valid=1", valid_o, lat);
    end
    run_op(32'h3F800000, 32'h40400000, lat);
    total++;
    if (lat !== 28 || result !== THIRD) begin
      bad++;
      $display("FAIL b2b_second: lat=%0d result=%h, want 28 %h", lat, result, THIRD);
    end
  endtask

  task automatic test_busy_ignore;
    int lat;
    int extra;
    a = 32'h40C00000; b = 32'h40000000; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 200) begin
      if (lat == 3 || lat == 20) begin
        a = 32'h3F800000; b = 32'h00000000; valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    valid_i = 1'b0;
    total++;
    if (lat !== 28 || result !== 32'h40400000 || dbz !== 1'b0) begin
      bad++;
      $display("FAIL busy_ignore: lat=%0d result=%h dbz=%b, want 28 40400000 0", lat, result, dbz);
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid_o) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL busy_no_extra: extra valid pulses=%0d, want 0", extra);
    end
  endtask

  task automatic test_clk_en;
    int lat;
    a = 32'h3F800000; b = 32'h40400000; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 200) begin
      clk_en = !(lat >= 5 && lat < 15);
      @(posedge clk); #1;
      lat++;
    end
    clk_en = 1'b1;
    total++;
    if (lat !== 38 || result !== THIRD) begin
      bad++;
      $display("FAIL clk_en_stall: lat=%0d result=%h, want 38 %h", lat, result, THIRD);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    int lat;
    a = 32'h40C00000; b = 32'h40000000; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    total++;
    if (fu_state !== FREE || valid_o !== 1'b0 || result !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid: state=%0d valid=%b result=%h, want FREE 0 00000000", fu_state, valid_o, result);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid_o) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL reset_abort: valid pulses after reset=%0d, want 0", seen);
    end
    run_op(32'h40C00000, 32'h40000000, lat);
    total++;
    if (lat !== 28 || result !== 32'h40400000) begin
      bad++;
      $display("FAIL post_reset_op: lat=%0d result=%h, want 28 40400000", lat, result);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_range();
    test_back_to_back();
    test_busy_ignore();
    test_clk_en();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
